// File: rtl/rrv64_core_vec_param_pkg.sv
// rrv64_core_vec_param_pkg: vector core widths and the writeback buffer entry type
package rrv64_core_vec_param_pkg;
    localparam int VREG_ADDR_WIDTH = 5;
    localparam int VFULEN = 64;
    typedef struct packed {
        logic [VREG_ADDR_WIDTH-1:0] addr;
        logic [VFULEN-1:0] data;
    } vrf_wb_entry_t;
endpackage

// File: rtl/vrf_wb_buffer.sv
// vrf_wb_buffer: two-in two-out circular writeback FIFO in front of a banked vector regfile
module vrf_wb_buffer
    import rrv64_core_vec_param_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = VREG_ADDR_WIDTH,
    parameter int DW = VFULEN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fu0_vld,
    input  logic          fu1_vld,
    output logic          fu0_rdy,
    output logic          fu1_rdy,
    input  logic [AW-1:0] fu0_addr,
    input  logic [AW-1:0] fu1_addr,
    input  logic [DW-1:0] fu0_data,
    input  logic [DW-1:0] fu1_data,
    output logic          wr0_vld,
    output logic          wr1_vld,
    output logic [AW-1:0] waddr0,
    output logic [AW-1:0] waddr1,
    output logic [DW-1:0] wdata0,
    output logic [DW-1:0] wdata1,
    input  logic          wr0_conflict,
    input  logic          wr1_conflict,
    output logic          empty,
    output logic [15:0]   conflict_cnt
);
    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);
    localparam logic [CW:0] FULL1 = (CW+1)'(DEPTH - 1);
    localparam logic [CW:0] ONE = (CW+1)'(1);
    localparam logic [CW:0] TWO = (CW+1)'(2);
    vrf_wb_entry_t mem [DEPTH];
    logic [CW-1:0] head, tail, h1, t1;
    logic [CW:0] count, n_push, n_pop;
    logic sec_done, push0, push1, w0, w1, inc;
    assign h1 = head + 1'b1;
    assign t1 = tail + 1'b1;
    assign fu0_rdy = count < FULL;
    assign fu1_rdy = count < FULL1;
    assign push0 = fu0_vld & fu0_rdy;
    assign push1 = fu1_vld & fu1_rdy;
    assign wr0_vld = count != '0;
    assign wr1_vld = (count >= TWO) & ~sec_done & (mem[h1].addr != mem[head].addr);
    assign waddr0 = mem[head].addr;
    assign wdata0 = mem[head].data;
    assign waddr1 = mem[h1].addr;
    assign wdata1 = mem[h1].data;
    assign w0 = wr0_vld & ~wr0_conflict;
    assign w1 = wr1_vld & ~wr1_conflict;
    assign n_push = (CW+1)'(push0) + (CW+1)'(push1);
    assign n_pop = w0 ? ((w1 | sec_done) ? TWO : ONE) : '0;
    assign inc = (wr0_vld & wr0_conflict) | (wr1_vld & wr1_conflict);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            sec_done <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            head <= head + n_pop[CW-1:0];
            tail <= tail + n_push[CW-1:0];
            count <= count + n_push - n_pop;
            sec_done <= (n_pop != '0) ? 1'b0 : (sec_done | (wr0_vld & wr0_conflict & w1));
            conflict_cnt <= conflict_cnt + 16'(inc & ~&conflict_cnt);
        end
    end
    always_ff @(posedge clk) begin
        if (push0) mem[tail] <= '{addr: fu0_addr, data: fu0_data};
        if (push1) mem[push0 ? t1 : tail] <= '{addr: fu1_addr, data: fu1_data};
    end
endmodule

// File: tb/tb_vrf_wb_buffer.sv
// tb_vrf_wb_buffer: directed-vector checks of the writeback buffer
module tb_vrf_wb_buffer;
    import rrv64_core_vec_param_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic fu0_vld, fu1_vld, fu0_rdy, fu1_rdy;
    logic [VREG_ADDR_WIDTH-1:0] fu0_addr, fu1_addr, waddr0, waddr1;
    logic [VFULEN-1:0] fu0_data, fu1_data, wdata0, wdata1;
    logic wr0_vld, wr1_vld, wr0_conflict, wr1_conflict, empty;
    logic [15:0] conflict_cnt;
    int checks = 0;
    int errors = 0;
    vrf_wb_buffer dut (
        .clk(clk), .rst(rst),
        .fu0_vld(fu0_vld), .fu1_vld(fu1_vld), .fu0_rdy(fu0_rdy), .fu1_rdy(fu1_rdy),
        .fu0_addr(fu0_addr), .fu1_addr(fu1_addr), .fu0_data(fu0_data), .fu1_data(fu1_data),
        .wr0_vld(wr0_vld), .wr1_vld(wr1_vld), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .wr0_conflict(wr0_conflict), .wr1_conflict(wr1_conflict),
        .empty(empty), .conflict_cnt(conflict_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic v0, input int a0, input int d0, input logic v1, input int a1, input int d1);
        fu0_vld = v0;
        fu0_addr = VREG_ADDR_WIDTH'(a0);
        fu0_data = VFULEN'(d0);
        fu1_vld = v1;
        fu1_addr = VREG_ADDR_WIDTH'(a1);
        fu1_data = VFULEN'(d1);
        step;
        fu0_vld = 1'b0;
        fu1_vld = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        fu0_vld = 0; fu1_vld = 0; fu0_addr = '0; fu1_addr = '0; fu0_data = '0; fu1_data = '0;
        wr0_conflict = 0; wr1_conflict = 0;
        step; step;
        rst = 1'b0;
        check("rst_wr0_vld", wr0_vld, 0);
        check("rst_wr1_vld", wr1_vld, 0);
        check("rst_empty", empty, 1);
        check("rst_fu0_rdy", fu0_rdy, 1);
        check("rst_fu1_rdy", fu1_rdy, 1);
        check("rst_cnt", conflict_cnt, 0);
        push(1, 5, 'hA, 0, 0, 0);
        check("single_wr0_vld", wr0_vld, 1);
        check("single_waddr0", waddr0, 5);
        check("single_wdata0", wdata0, 'hA);
        check("single_wr1_vld", wr1_vld, 0);
        check("single_empty", empty, 0);
        step;
        check("single_drained", empty, 1);
        push(1, 3, 'h33, 1, 9, 'h99);
        check("dual_waddr0", waddr0, 3);
        check("dual_wr1_vld", wr1_vld, 1);
        check("dual_waddr1", waddr1, 9);
        check("dual_wdata1", wdata1, 'h99);
        step;
        check("dual_drained", empty, 1);
        push(1, 7, 'h71, 1, 7, 'h72);
        check("same_wr1_vld", wr1_vld, 0);
        check("same_first", wdata0, 'h71);
        step;
        check("same_wr0_vld", wr0_vld, 1);
        check("same_second", wdata0, 'h72);
        check("same_wr1_vld2", wr1_vld, 0);
        step;
        check("same_drained", empty, 1);
        push(1, 2, 'h20, 1, 4, 'h40);
        wr0_conflict = 1;
        check("sec_wr1_vld", wr1_vld, 1);
        step;
        wr0_conflict = 0;
        check("sec_retry_addr", waddr0, 2);
        check("sec_retry_data", wdata0, 'h20);
        check("sec_wr1_off", wr1_vld, 0);
        check("sec_cnt", conflict_cnt, 1);
        step;
        check("sec_drained", empty, 1);
        check("sec_cnt_hold", conflict_cnt, 1);
        wr0_conflict = 1;
        wr1_conflict = 1;
        for (int k = 0; k < 4; k++) push(1, 10 + 2 * k, 'h100 + 2 * k, 1, 11 + 2 * k, 'h101 + 2 * k);
        check("full_fu0_rdy", fu0_rdy, 0);
        check("full_fu1_rdy", fu1_rdy, 0);
        push(1, 31, 'hBAD, 1, 30, 'hBAD);
        check("full_head", waddr0, 10);
        check("full_cnt", conflict_cnt, 5);
        wr0_conflict = 0;
        wr1_conflict = 0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain%0d_a0", j), waddr0, 10 + 2 * j);
            check($sformatf("drain%0d_d0", j), wdata0, 'h100 + 2 * j);
            check($sformatf("drain%0d_a1", j), waddr1, 11 + 2 * j);
            check($sformatf("drain%0d_v1", j), wr1_vld, 1);
            step;
        end
        check("drain_empty", empty, 1);
        wr0_conflict = 1;
        wr1_conflict = 1;
        push(1, 1, 1, 1, 2, 2);
        push(1, 3, 3, 1, 4, 4);
        push(1, 5, 5, 0, 0, 0);
        check("pre_rst_empty", empty, 0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        wr0_conflict = 0;
        wr1_conflict = 0;
        check("mid_rst_wr0_vld", wr0_vld, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_cnt", conflict_cnt, 0);
        check("mid_rst_fu1_rdy", fu1_rdy, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vrf_wb_buffer.md
VRF_WB_BUFFER -- requirements
Module: vrf_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of buffered writeback entries (power of two, >=4).
REQ-002 SHALL have parameter AW, default VREG_ADDR_WIDTH, meaning vector register address width.
REQ-003 SHALL have parameter DW, default VFULEN, meaning write data width.
REQ-004 SHALL have port clk  input  1  clock; one clock domain, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports fu0_vld/fu1_vld  input  1 each  result valid from functional unit 0/1.
REQ-007 SHALL have ports fu0_rdy/fu1_rdy  output  1 each  buffer can accept that unit's result this cycle.
REQ-008 SHALL have ports fu0_addr/fu1_addr  input  AW each  destination vector register.
REQ-009 SHALL have ports fu0_data/fu1_data  input  DW each  result data.
REQ-010 SHALL have ports wr0_vld/wr1_vld  output  1 each  regfile write request, port 0/1.
REQ-011 SHALL have ports waddr0/waddr1  output  AW each, and wdata0/wdata1  output  DW each.
REQ-012 SHALL have ports wr0_conflict/wr1_conflict  input  1 each  regfile bank conflict; write not performed this cycle.
REQ-013 SHALL have ports empty  output  1, and conflict_cnt  output  16  saturating count of conflict cycles.

Function
REQ-014 SHALL hold entries in a circular FIFO (head, tail, count 0..DEPTH); wrap at DEPTH.
REQ-015 SHALL assert fu0_rdy when registered free slots >=1 and fu1_rdy when >=2, independent of vld and of same-cycle pops.
REQ-016 SHALL push on fuN_vld & fuN_rdy; with both pushing, fu0 takes tail, fu1 takes tail+1.
REQ-017 SHALL drive wr0_vld = count>=1 with head entry; push-to-wr0 latency 1 cycle minimum, no bypass.
REQ-018 SHALL drive wr1_vld = count>=2 & ~sec_done & addr(head+1) != addr(head), with entry head+1.
REQ-019 SHALL treat a port as written when wrN_vld & ~wrN_conflict.
REQ-020 SHALL pop 1 when wr0 written and (count==1 or wr1 not written and ~sec_done); pop 2 when wr0 written and (wr1 written or sec_done).
REQ-021 SHALL set sec_done when wr0 conflicts and wr1 written; clear it on any pop of head.
REQ-022 SHALL pop 0 when wr0 conflicts, retrying the same head next cycle with unchanged addr/data.
REQ-023 SHALL update count as count + pushes - pops in one cycle; simultaneous push/pop at full or empty SHALL never overflow/underflow.
REQ-024 SHALL increment conflict_cnt once per cycle where (wr0_vld&wr0_conflict)|(wr1_vld&wr1_conflict), saturating at 16'hFFFF.
REQ-025 SHALL assert empty when count==0.

Reset
REQ-026 SHALL on rst clear head, tail, count, sec_done, conflict_cnt; outputs: wr0_vld=wr1_vld=0, empty=1, fu0_rdy=fu1_rdy=1 the cycle after reset.
REQ-027 SHALL discard all buffered entries when rst is asserted mid-operation; entry data storage needs no reset.

Structure
REQ-028 SHALL take VREG_ADDR_WIDTH and VFULEN from rrv64_core_vec_param_pkg; a vrf_wb_entry_t typedef (addr, data) SHALL be added to that package.
REQ-029 SHALL be a single module with no sub-modules; storage is a flop array of vrf_wb_entry_t.

Verification
REQ-030 Single push fu0 addr=5 data=A, no conflict -> wr0_vld=1 waddr0=5 next cycle, empty=1 the cycle after.
REQ-031 Dual push addr 3 and 9, no conflict -> both ports written in one cycle, count 2->0.
REQ-032 Dual push addr 7 and 7 -> wr1_vld=0; cycle 1 writes first, cycle 2 writes second; in-order result.
REQ-033 Entries 2,4 queued; wr0_conflict=1 once, wr1 ok -> sec_done=1, next cycle wr0 retries addr 2, wr1_vld=0, both pop, conflict_cnt=1.
REQ-034 Fill to DEPTH with wr0_conflict held high -> fu0_rdy=fu1_rdy=0, no overwrite; release conflict -> drain in order with wrap.
REQ-035 Assert rst with 5 entries queued -> next cycle wr0_vld=0, empty=1, conflict_cnt=0.
